// File: rtl/demo_seq_pkg.sv
// rtl/demo_seq_pkg.sv - shared constants, scene entry type and scene table for the scene sequencer
// Scene table contents are fixed at build time; dur is counted in vsync frame ticks.
package demo_seq_pkg;

  localparam logic [1:0] ST_LD_COLOR  = 2'd0;
  localparam logic [1:0] ST_LD_SPRITE = 2'd1;
  localparam logic [1:0] ST_LD_BG     = 2'd2;
  localparam logic [1:0] ST_HOLD      = 2'd3;

  localparam logic [1:0] OP_COLOR  = 2'd0;
  localparam logic [1:0] OP_SPRITE = 2'd1;
  localparam logic [1:0] OP_BG     = 2'd2;
  localparam logic [1:0] OP_LOOP   = 2'd3;

  localparam int ROM_DUR_W = 8;

  typedef struct packed {
    logic [5:0]           color;
    logic [1:0]           sprite;
    logic [3:0]           bg;
    logic [ROM_DUR_W-1:0] dur;
  } scene_t;

  function automatic scene_t scene_rom(input logic [7:0] idx);
    scene_t s;
    case (idx)
      8'd0:    s = '{color: 6'h3F, sprite: 2'd0, bg: 4'd1,  dur: 8'd60};
      8'd1:    s = '{color: 6'h00, sprite: 2'd1, bg: 4'd3,  dur: 8'd120};
      8'd2:    s = '{color: 6'h0C, sprite: 2'd0, bg: 4'd10, dur: 8'd90};
      default: s = '{color: 6'h30, sprite: 2'd1, bg: 4'd0,  dur: 8'd30};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/demo_frame_tick.sv
// rtl/demo_frame_tick.sv - vsync rising-edge detector and per-scene frame counter
// The tick is combinational from the live vsync so the counter and FSM act on the same edge.
module demo_frame_tick #(
  parameter int DUR_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vsync,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic             o_tick,
  output logic [DUR_W-1:0] o_frame_cnt
);

  logic             r_vsync_q;
  logic [DUR_W-1:0] r_frame_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vsync_q   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_vsync_q <= i_vsync;
      if (i_clr) begin
        r_frame_cnt <= '0;
      end else if (i_inc) begin
        r_frame_cnt <= r_frame_cnt + DUR_W'(1);
      end
    end
  end

  assign o_tick      = i_vsync & ~r_vsync_q;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: rtl/demo_scene_sequencer.sv
// rtl/demo_scene_sequencer.sv - scene table sequencer driving the vga_control byte
// Loads each scene in three writes, holds it for dur frames, and lets a host inject bytes while holding.
module demo_scene_sequencer
  import demo_seq_pkg::*;
#(
  parameter int NUM_SCENES = 8,
  parameter int SCENE_W    = 3,
  parameter int DUR_W      = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_vsync,
  input  logic               i_auto_en,
  input  logic               i_cmd_valid,
  input  logic [7:0]         i_cmd_data,
  output logic               o_cmd_ready,
  output logic [7:0]         o_vga_control,
  output logic [SCENE_W-1:0] o_scene_idx,
  output logic               o_loading
);

  logic [1:0]         r_state;
  logic [SCENE_W-1:0] r_scene_idx;
  logic [7:0]         r_vga_control;
  logic               r_pending_adv;

  logic               w_tick;
  logic [DUR_W-1:0]   w_frame_cnt;
  scene_t             w_entry;
  logic [DUR_W-1:0]   w_dur;
  logic [DUR_W-1:0]   w_dur_m1;
  logic               w_hold;
  logic               w_accept;
  logic               w_frame_evt;
  logic               w_expire;
  logic               w_advance;
  logic               w_inc;
  logic               w_clr;
  logic [SCENE_W-1:0] w_next_idx;

  assign w_entry  = scene_rom(8'(r_scene_idx));
  assign w_dur    = DUR_W'(w_entry.dur);
  // A zero duration behaves like one frame, so compare against 0 in that case.
  assign w_dur_m1 = (w_dur == '0) ? '0 : w_dur - DUR_W'(1);

  assign w_hold      = (r_state == ST_HOLD);
  assign w_accept    = w_hold & i_cmd_valid;
  assign w_frame_evt = w_hold & i_auto_en & w_tick & ~r_pending_adv;
  assign w_expire    = w_frame_evt & (w_frame_cnt == w_dur_m1);
  assign w_inc       = w_frame_evt & ~w_expire;
  // An expiry that collides with a host accept is parked in r_pending_adv and taken next free cycle.
  assign w_advance   = w_hold & ~w_accept & (r_pending_adv | w_expire);
  assign w_clr       = (r_state == ST_LD_BG);
  assign w_next_idx  = (r_scene_idx == SCENE_W'(NUM_SCENES - 1)) ? '0 : r_scene_idx + SCENE_W'(1);

  demo_frame_tick #(
    .DUR_W (DUR_W)
  ) u_frame_tick (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_vsync     (i_vsync),
    .i_clr       (w_clr),
    .i_inc       (w_inc),
    .o_tick      (w_tick),
    .o_frame_cnt (w_frame_cnt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_LD_COLOR;
      r_scene_idx   <= '0;
      r_vga_control <= 8'h80;
      r_pending_adv <= 1'b0;
    end else begin
      case (r_state)
        ST_LD_COLOR: begin
          r_vga_control <= {OP_COLOR, w_entry.color};
          r_state       <= ST_LD_SPRITE;
        end
        ST_LD_SPRITE: begin
          r_vga_control <= {OP_SPRITE, 4'b0000, w_entry.sprite};
          r_state       <= ST_LD_BG;
        end
        ST_LD_BG: begin
          r_vga_control <= {OP_BG, 2'b00, w_entry.bg};
          r_state       <= ST_HOLD;
        end
        default: begin
          if (w_accept) begin
            r_vga_control <= i_cmd_data;
            if (w_expire) begin
              r_pending_adv <= 1'b1;
            end
          end else if (w_advance) begin
            r_scene_idx   <= w_next_idx;
            r_pending_adv <= 1'b0;
            r_state       <= ST_LD_COLOR;
          end
        end
      endcase
    end
  end

  assign o_cmd_ready   = w_hold;
  assign o_vga_control = r_vga_control;
  assign o_scene_idx   = r_scene_idx;
  assign o_loading     = ~w_hold;

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// tb/tb_demo_scene_sequencer.sv - directed self-checking bench for demo_scene_sequencer
module tb_demo_scene_sequencer;

  logic       clk;
  logic       rst;
  logic       vsync;
  logic       auto_en;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic [7:0] vga_control;
  logic [2:0] scene_idx;
  logic       loading;

  int checks = 0;
  int errors = 0;

  demo_scene_sequencer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_vsync       (vsync),
    .i_auto_en     (auto_en),
    .i_cmd_valid   (cmd_valid),
    .i_cmd_data    (cmd_data),
    .o_cmd_ready   (cmd_ready),
    .o_vga_control (vga_control),
    .o_scene_idx   (scene_idx),
    .o_loading     (loading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1;
      step();
      vsync = 1'b0;
      step();
    end
  endtask

  initial begin
    logic [7:0] exp_idx;
    logic [7:0] exp_col;
    rst = 1'b1; vsync = 1'b0; auto_en = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00;
    step(); step();
    chk("rst_vga", vga_control, 8'h80);
    chk("rst_idx", {5'b0, scene_idx}, 8'd0);
    chk("rst_loading", {7'b0, loading}, 8'd1);
    chk("rst_ready", {7'b0, cmd_ready}, 8'd0);

    rst = 1'b0;
    step(); chk("ld0_color", vga_control, 8'h3F); chk("ld0_loading", {7'b0, loading}, 8'd1);
    step(); chk("ld0_sprite", vga_control, 8'h40);
    step(); chk("ld0_bg", vga_control, 8'h81); chk("ld0_done", {7'b0, loading}, 8'd0);
    chk("ld0_ready", {7'b0, cmd_ready}, 8'd1);
    step(); chk("hold0", vga_control, 8'h81);

    ticks(59);
    chk("t59_vga", vga_control, 8'h81);
    chk("t59_idx", {5'b0, scene_idx}, 8'd0);
    vsync = 1'b1; step();
    chk("t60_idx", {5'b0, scene_idx}, 8'd1);
    chk("t60_loading", {7'b0, loading}, 8'd1);
    vsync = 1'b0; step();
    chk("ld1_color", vga_control, 8'h00);
    step(); chk("ld1_sprite", vga_control, 8'h41);
    step(); chk("ld1_bg", vga_control, 8'h83); chk("ld1_done", {7'b0, loading}, 8'd0);

    ticks(5);
    cmd_valid = 1'b1; cmd_data = 8'hC0;
    chk("cmd_ready_hold", {7'b0, cmd_ready}, 8'd1);
    step(); cmd_valid = 1'b0;
    chk("cmd_c0", vga_control, 8'hC0);
    step(); chk("cmd_c0_held", vga_control, 8'hC0);
    ticks(114);
    chk("cnt_kept_idx", {5'b0, scene_idx}, 8'd1);
    chk("cnt_kept_vga", vga_control, 8'hC0);

    vsync = 1'b1; cmd_valid = 1'b1; cmd_data = 8'hC5;
    step();
    chk("coll_vga", vga_control, 8'hC5);
    chk("coll_idx", {5'b0, scene_idx}, 8'd1);
    chk("coll_loading", {7'b0, loading}, 8'd0);
    vsync = 1'b0; cmd_valid = 1'b0;
    step();
    chk("defer_idx", {5'b0, scene_idx}, 8'd2);
    chk("defer_vga", vga_control, 8'hC5);
    cmd_valid = 1'b1; cmd_data = 8'hC7;
    chk("load_not_ready", {7'b0, cmd_ready}, 8'd0);
    step(); chk("ld2_color", vga_control, 8'h0C);
    step(); chk("ld2_sprite", vga_control, 8'h40);
    step(); chk("ld2_bg", vga_control, 8'h8A);
    chk("ld2_ready", {7'b0, cmd_ready}, 8'd1);
    step(); cmd_valid = 1'b0;
    chk("waited_cmd", vga_control, 8'hC7);
    chk("once_idx", {5'b0, scene_idx}, 8'd2);

    ticks(10);
    auto_en = 1'b0;
    ticks(200);
    chk("frz_idx", {5'b0, scene_idx}, 8'd2);
    chk("frz_vga", vga_control, 8'hC7);
    chk("frz_loading", {7'b0, loading}, 8'd0);
    auto_en = 1'b1;
    ticks(79);
    chk("rem79_idx", {5'b0, scene_idx}, 8'd2);
    ticks(1);
    chk("rem80_idx", {5'b0, scene_idx}, 8'd3);
    chk("ld3_color", vga_control, 8'h30);
    step(); step();
    chk("ld3_bg", vga_control, 8'h80);

    for (int s = 3; s < 8; s++) begin
      exp_idx = (s == 7) ? 8'd0 : 8'(s + 1);
      exp_col = (s == 7) ? 8'h3F : 8'h30;
      ticks(29);
      chk("scn_hold_idx", {5'b0, scene_idx}, 8'(s));
      ticks(1);
      chk("scn_next_idx", {5'b0, scene_idx}, exp_idx);
      chk("scn_next_color", vga_control, exp_col);
      step(); step();
    end
    chk("wrap_bg", vga_control, 8'h81);

    ticks(59);
    vsync = 1'b1; cmd_valid = 1'b1; cmd_data = 8'hC3;
    step();
    chk("pend_vga", vga_control, 8'hC3);
    rst = 1'b1;
    #1;
    chk("arst_pend_vga", vga_control, 8'h80);
    chk("arst_pend_loading", {7'b0, loading}, 8'd1);
    vsync = 1'b0; cmd_valid = 1'b0;
    step();
    rst = 1'b0;
    step(); chk("rs_color", vga_control, 8'h3F);
    step(); chk("rs_sprite", vga_control, 8'h40);
    step(); chk("rs_bg", vga_control, 8'h81);
    step(); step();
    chk("rs_nopend_idx", {5'b0, scene_idx}, 8'd0);
    chk("rs_nopend_vga", vga_control, 8'h81);

    ticks(60);
    chk("mid_ld_idx", {5'b0, scene_idx}, 8'd1);
    chk("mid_ld_vga", vga_control, 8'h00);
    rst = 1'b1;
    #1;
    chk("arst_ld_vga", vga_control, 8'h80);
    chk("arst_ld_idx", {5'b0, scene_idx}, 8'd0);
    chk("arst_ld_ready", {7'b0, cmd_ready}, 8'd0);
    step();
    rst = 1'b0;
    step(); chk("rs2_color", vga_control, 8'h3F);
    step(); chk("rs2_sprite", vga_control, 8'h40);
    step(); chk("rs2_bg", vga_control, 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
